// File: rtl/ras_circ.sv
// Circular return-address stack: push/pop/replace-top with flush, wrap-around
// overwrite of the oldest entry on overflow, and registered over/underflow pulses.
module ras_circ #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned VLEN  = 64,
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [VLEN-1:0] data_i,
    output logic [VLEN-1:0] addr_o,
    output logic            valid_o,
    output logic [CntW-1:0] count_o,
    output logic            overflow_o,
    output logic            underflow_o
);

    localparam logic [PtrW-1:0] TpMax  = PtrW'(DEPTH - 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEPTH);

    logic [VLEN-1:0] mem_q [DEPTH];
    logic [PtrW-1:0] tp_q, tp_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;

    logic [PtrW-1:0] tp_inc, tp_dec;
    logic            mem_we;
    logic [PtrW-1:0] mem_waddr;
    logic [VLEN-1:0] mem_wdata;
    logic            full, empty;

    always_comb begin
        // Explicit modulo so non-power-of-two depths wrap correctly.
        tp_inc    = (tp_q == TpMax) ? '0 : tp_q + PtrW'(1);
        tp_dec    = (tp_q == '0) ? TpMax : tp_q - PtrW'(1);
        full      = (cnt_q == CntMax);
        empty     = (cnt_q == '0);

        tp_d      = tp_q;
        cnt_d     = cnt_q;
        ovf_d     = 1'b0;
        unf_d     = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = tp_q;
        mem_wdata = data_i;

        if (flush_i) begin
            tp_d  = '0;
            cnt_d = '0;
        end else if (push_i && pop_i) begin
            mem_we = 1'b1;
            if (empty) begin
                cnt_d = CntW'(1);
            end
        end else if (push_i) begin
            tp_d      = tp_inc;
            mem_we    = 1'b1;
            mem_waddr = tp_inc;
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end else if (pop_i) begin
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                tp_d  = tp_dec;
                cnt_d = cnt_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            tp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (mem_we) begin
                mem_q[mem_waddr] <= mem_wdata;
            end
            tp_q  <= tp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // All outputs come from flops only; addr_o is unqualified, consumers gate with valid_o.
    assign addr_o      = mem_q[tp_q];
    assign valid_o     = (cnt_q != '0);
    assign count_o     = cnt_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

`ifndef SYNTHESIS
    a_cnt_range: assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_q <= CntMax);
    a_tp_range:  assert property (@(posedge clk_i) disable iff (!rst_ni) tp_q <= TpMax);
    a_pulse_excl: assert property (@(posedge clk_i) disable iff (!rst_ni) !(ovf_q && unf_q));
`endif

endmodule

// File: tb/tb_ras_circ.sv
// Bench for ras_circ: three instances (DEPTH 4, 3, 1) share one stimulus bus and are
// checked by directed scenarios and a queue-based stack model under random traffic.
module tb_ras_circ;

    localparam int VW = 32;

    logic          clk_i   = 1'b0;
    logic          rst_ni  = 1'b0;
    logic          flush_i = 1'b0;
    logic          push_i  = 1'b0;
    logic          pop_i   = 1'b0;
    logic [VW-1:0] data_i  = '0;

    always #5 clk_i = ~clk_i;

    logic [VW-1:0] a4, a3, a1;
    logic          v4, v3, v1;
    logic [2:0]    c4;
    logic [1:0]    c3;
    logic [0:0]    c1;
    logic          o4, o3, o1;
    logic          u4, u3, u1;

    ras_circ #(.DEPTH(4), .VLEN(VW)) dut4 (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .push_i(push_i), .pop_i(pop_i),
        .data_i(data_i), .addr_o(a4), .valid_o(v4), .count_o(c4),
        .overflow_o(o4), .underflow_o(u4)
    );
    ras_circ #(.DEPTH(3), .VLEN(VW)) dut3 (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .push_i(push_i), .pop_i(pop_i),
        .data_i(data_i), .addr_o(a3), .valid_o(v3), .count_o(c3),
        .overflow_o(o3), .underflow_o(u3)
    );
    ras_circ #(.DEPTH(1), .VLEN(VW)) dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .push_i(push_i), .pop_i(pop_i),
        .data_i(data_i), .addr_o(a1), .valid_o(v1), .count_o(c1),
        .overflow_o(o1), .underflow_o(u1)
    );

    // Index 0 = DEPTH 4, 1 = DEPTH 3, 2 = DEPTH 1.
    logic [VW-1:0] obs_addr [3];
    logic          obs_valid[3];
    logic [7:0]    obs_cnt  [3];
    logic          obs_ovf  [3];
    logic          obs_unf  [3];

    assign obs_addr[0] = a4;  assign obs_addr[1] = a3;  assign obs_addr[2] = a1;
    assign obs_valid[0] = v4; assign obs_valid[1] = v3; assign obs_valid[2] = v1;
    assign obs_cnt[0] = 8'(c4); assign obs_cnt[1] = 8'(c3); assign obs_cnt[2] = 8'(c1);
    assign obs_ovf[0] = o4;   assign obs_ovf[1] = o3;   assign obs_ovf[2] = o1;
    assign obs_unf[0] = u4;   assign obs_unf[1] = u3;   assign obs_unf[2] = u1;

    // Reference model: each stack is a queue, newest entry at the back.
    logic [VW-1:0] mq[3][$];
    int            dep[3] = '{4, 3, 1};
    logic          eo[3]  = '{1'b0, 1'b0, 1'b0};
    logic          eu[3]  = '{1'b0, 1'b0, 1'b0};

    int n_chk  = 0;
    int n_fail = 0;

    task automatic model_update(input logic f, input logic p, input logic o, input logic [VW-1:0] d);
        for (int k = 0; k < 3; k++) begin
            eo[k] = 1'b0;
            eu[k] = 1'b0;
            if (f) begin
                mq[k].delete();
            end else if (p && o) begin
                if (mq[k].size() == 0) mq[k].push_back(d);
                else mq[k][mq[k].size()-1] = d;
            end else if (p) begin
                mq[k].push_back(d);
                if (mq[k].size() > dep[k]) begin
                    void'(mq[k].pop_front());
                    eo[k] = 1'b1;
                end
            end else if (o) begin
                if (mq[k].size() == 0) eu[k] = 1'b1;
                else void'(mq[k].pop_back());
            end
        end
    endtask

    // Drive one cycle at the falling edge, then return #1 after the rising edge.
    task automatic step(input logic f, input logic p, input logic o, input logic [VW-1:0] d);
        @(negedge clk_i);
        flush_i = f;
        push_i  = p;
        pop_i   = o;
        data_i  = d;
        model_update(f, p, o, d);
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        push_i  = 1'b0;
        pop_i   = 1'b0;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        for (int k = 0; k < 3; k++) begin
            n_chk += 5;
            if (obs_addr[k] !== '0) begin n_fail++; $display("FAIL reset_addr[%0d]: got %0h expected 0", k, obs_addr[k]); end
            if (obs_valid[k] !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d]: got %b expected 0", k, obs_valid[k]); end
            if (obs_cnt[k] !== 8'd0) begin n_fail++; $display("FAIL reset_count[%0d]: got %0d expected 0", k, obs_cnt[k]); end
            if (obs_ovf[k] !== 1'b0) begin n_fail++; $display("FAIL reset_ovf[%0d]: got %b expected 0", k, obs_ovf[k]); end
            if (obs_unf[k] !== 1'b0) begin n_fail++; $display("FAIL reset_unf[%0d]: got %b expected 0", k, obs_unf[k]); end
        end
    endtask

    task automatic test_lifo;
        logic [VW-1:0] tops[3] = '{32'h300, 32'h200, 32'h100};
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, 32'h100);
        step(1'b0, 1'b1, 1'b0, 32'h200);
        step(1'b0, 1'b1, 1'b0, 32'h300);
        for (int i = 0; i < 3; i++) begin
            n_chk += 3;
            if (obs_addr[0] !== tops[i]) begin n_fail++; $display("FAIL lifo_addr[%0d]: got %0h expected %0h", i, obs_addr[0], tops[i]); end
            if (obs_cnt[0] !== 8'(3 - i)) begin n_fail++; $display("FAIL lifo_count[%0d]: got %0d expected %0d", i, obs_cnt[0], 3 - i); end
            if (obs_valid[0] !== 1'b1) begin n_fail++; $display("FAIL lifo_valid[%0d]: got %b expected 1", i, obs_valid[0]); end
            step(1'b0, 1'b0, 1'b1, '0);
        end
        n_chk += 2;
        if (obs_valid[0] !== 1'b0) begin n_fail++; $display("FAIL lifo_empty_valid: got %b expected 0", obs_valid[0]); end
        if (obs_cnt[0] !== 8'd0) begin n_fail++; $display("FAIL lifo_empty_count: got %0d expected 0", obs_cnt[0]); end
    endtask

    task automatic test_overflow;
        step(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0, VW'((i + 1) * 16));
            n_chk += 2;
            if (obs_ovf[0] !== (i == 4)) begin n_fail++; $display("FAIL ovf_pulse[%0d]: got %b expected %b", i, obs_ovf[0], i == 4); end
            if (obs_cnt[0] !== 8'((i < 4) ? i + 1 : 4)) begin n_fail++; $display("FAIL ovf_count[%0d]: got %0d", i, obs_cnt[0]); end
        end
        for (int i = 0; i < 4; i++) begin
            n_chk += 2;
            if (obs_addr[0] !== VW'(32'h50 - 16 * i)) begin n_fail++; $display("FAIL ovf_pop_addr[%0d]: got %0h expected %0h", i, obs_addr[0], 32'h50 - 16 * i); end
            if (obs_valid[0] !== 1'b1) begin n_fail++; $display("FAIL ovf_pop_valid[%0d]: got %b expected 1", i, obs_valid[0]); end
            step(1'b0, 1'b0, 1'b1, '0);
            n_chk++;
            if (obs_ovf[0] !== 1'b0) begin n_fail++; $display("FAIL ovf_after_pop[%0d]: got %b expected 0", i, obs_ovf[0]); end
        end
        n_chk++;
        if (obs_valid[0] !== 1'b0) begin n_fail++; $display("FAIL ovf_drained_valid: got %b expected 0", obs_valid[0]); end
    endtask

    task automatic test_wrap3;
        logic [VW-1:0] exp_pop[3] = '{32'hE, 32'hD, 32'hB};
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, 32'hA);
        step(1'b0, 1'b1, 1'b0, 32'hB);
        step(1'b0, 1'b1, 1'b0, 32'hC);
        step(1'b0, 1'b0, 1'b1, '0);
        step(1'b0, 1'b1, 1'b0, 32'hD);
        n_chk++;
        if (obs_ovf[1] !== 1'b0) begin n_fail++; $display("FAIL wrap3_ovf_d: got %b expected 0", obs_ovf[1]); end
        step(1'b0, 1'b1, 1'b0, 32'hE);
        n_chk += 2;
        if (obs_ovf[1] !== 1'b1) begin n_fail++; $display("FAIL wrap3_ovf_e: got %b expected 1", obs_ovf[1]); end
        if (obs_cnt[1] !== 8'd3) begin n_fail++; $display("FAIL wrap3_count: got %0d expected 3", obs_cnt[1]); end
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (obs_addr[1] !== exp_pop[i]) begin n_fail++; $display("FAIL wrap3_pop[%0d]: got %0h expected %0h", i, obs_addr[1], exp_pop[i]); end
            step(1'b0, 1'b0, 1'b1, '0);
        end
        n_chk++;
        if (obs_valid[1] !== 1'b0) begin n_fail++; $display("FAIL wrap3_empty_valid: got %b expected 0", obs_valid[1]); end
    endtask

    task automatic test_underflow_replace;
        step(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'b1, '0);
            n_chk += 2;
            if (obs_unf[0] !== 1'b1) begin n_fail++; $display("FAIL unf_pulse[%0d]: got %b expected 1", i, obs_unf[0]); end
            if (obs_cnt[0] !== 8'd0) begin n_fail++; $display("FAIL unf_count[%0d]: got %0d expected 0", i, obs_cnt[0]); end
        end
        step(1'b0, 1'b0, 1'b0, '0);
        n_chk++;
        if (obs_unf[0] !== 1'b0) begin n_fail++; $display("FAIL unf_clear: got %b expected 0", obs_unf[0]); end
        step(1'b0, 1'b1, 1'b1, 32'hABC);
        n_chk += 4;
        if (obs_cnt[0] !== 8'd1) begin n_fail++; $display("FAIL replace_empty_count: got %0d expected 1", obs_cnt[0]); end
        if (obs_addr[0] !== 32'hABC) begin n_fail++; $display("FAIL replace_empty_addr: got %0h expected abc", obs_addr[0]); end
        if (obs_unf[0] !== 1'b0) begin n_fail++; $display("FAIL replace_empty_unf: got %b expected 0", obs_unf[0]); end
        if (obs_ovf[0] !== 1'b0) begin n_fail++; $display("FAIL replace_empty_ovf: got %b expected 0", obs_ovf[0]); end
        step(1'b0, 1'b1, 1'b1, 32'hDEF);
        n_chk += 2;
        if (obs_cnt[0] !== 8'd1) begin n_fail++; $display("FAIL replace_top_count: got %0d expected 1", obs_cnt[0]); end
        if (obs_addr[0] !== 32'hDEF) begin n_fail++; $display("FAIL replace_top_addr: got %0h expected def", obs_addr[0]); end
    endtask

    task automatic test_depth1;
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, 32'h1);
        n_chk += 2;
        if (obs_ovf[2] !== 1'b0) begin n_fail++; $display("FAIL d1_first_ovf: got %b expected 0", obs_ovf[2]); end
        if (obs_addr[2] !== 32'h1) begin n_fail++; $display("FAIL d1_first_addr: got %0h expected 1", obs_addr[2]); end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b0, VW'(i + 2));
            n_chk += 3;
            if (obs_ovf[2] !== 1'b1) begin n_fail++; $display("FAIL d1_ovf[%0d]: got %b expected 1", i, obs_ovf[2]); end
            if (obs_cnt[2] !== 8'd1) begin n_fail++; $display("FAIL d1_count[%0d]: got %0d expected 1", i, obs_cnt[2]); end
            if (obs_addr[2] !== VW'(i + 2)) begin n_fail++; $display("FAIL d1_addr[%0d]: got %0h expected %0h", i, obs_addr[2], i + 2); end
        end
        step(1'b0, 1'b0, 1'b1, '0);
        n_chk += 2;
        if (obs_valid[2] !== 1'b0) begin n_fail++; $display("FAIL d1_pop_valid: got %b expected 0", obs_valid[2]); end
        if (obs_ovf[2] !== 1'b0) begin n_fail++; $display("FAIL d1_pop_ovf: got %b expected 0", obs_ovf[2]); end
    endtask

    task automatic test_flush;
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, 32'h1);
        step(1'b0, 1'b1, 1'b0, 32'h2);
        step(1'b1, 1'b1, 1'b0, 32'h9);
        for (int k = 0; k < 3; k++) begin
            n_chk += 4;
            if (obs_cnt[k] !== 8'd0) begin n_fail++; $display("FAIL flush_count[%0d]: got %0d expected 0", k, obs_cnt[k]); end
            if (obs_valid[k] !== 1'b0) begin n_fail++; $display("FAIL flush_valid[%0d]: got %b expected 0", k, obs_valid[k]); end
            if (obs_ovf[k] !== 1'b0) begin n_fail++; $display("FAIL flush_ovf[%0d]: got %b expected 0", k, obs_ovf[k]); end
            if (obs_unf[k] !== 1'b0) begin n_fail++; $display("FAIL flush_unf[%0d]: got %b expected 0", k, obs_unf[k]); end
        end
    endtask

    task automatic test_async_reset;
        step(1'b0, 1'b1, 1'b0, 32'h77);
        step(1'b0, 1'b1, 1'b0, 32'h88);
        #2;
        rst_ni = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_chk += 5;
            if (obs_addr[k] !== '0) begin n_fail++; $display("FAIL areset_addr[%0d]: got %0h expected 0", k, obs_addr[k]); end
            if (obs_valid[k] !== 1'b0) begin n_fail++; $display("FAIL areset_valid[%0d]: got %b expected 0", k, obs_valid[k]); end
            if (obs_cnt[k] !== 8'd0) begin n_fail++; $display("FAIL areset_count[%0d]: got %0d expected 0", k, obs_cnt[k]); end
            if (obs_ovf[k] !== 1'b0) begin n_fail++; $display("FAIL areset_ovf[%0d]: got %b expected 0", k, obs_ovf[k]); end
            if (obs_unf[k] !== 1'b0) begin n_fail++; $display("FAIL areset_unf[%0d]: got %b expected 0", k, obs_unf[k]); end
            mq[k].delete();
            eo[k] = 1'b0;
            eu[k] = 1'b0;
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_random;
        logic f, p, o;
        for (int n = 0; n < 400; n++) begin
            f = ($urandom_range(0, 99) < 4);
            p = ($urandom_range(0, 99) < 55);
            o = ($urandom_range(0, 99) < 45);
            step(f, p, o, $urandom);
            for (int k = 0; k < 3; k++) begin
                n_chk += 4;
                if (obs_cnt[k] !== 8'(mq[k].size())) begin n_fail++; $display("FAIL rand_count[%0d] cyc %0d: got %0d expected %0d", k, n, obs_cnt[k], mq[k].size()); end
                if (obs_valid[k] !== (mq[k].size() != 0)) begin n_fail++; $display("FAIL rand_valid[%0d] cyc %0d: got %b", k, n, obs_valid[k]); end
                if (obs_ovf[k] !== eo[k]) begin n_fail++; $display("FAIL rand_ovf[%0d] cyc %0d: got %b expected %b", k, n, obs_ovf[k], eo[k]); end
                if (obs_unf[k] !== eu[k]) begin n_fail++; $display("FAIL rand_unf[%0d] cyc %0d: got %b expected %b", k, n, obs_unf[k], eu[k]); end
                if (mq[k].size() != 0) begin
                    n_chk++;
                    if (obs_addr[k] !== mq[k][$]) begin n_fail++; $display("FAIL rand_addr[%0d] cyc %0d: got %0h expected %0h", k, n, obs_addr[k], mq[k][$]); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lifo();
        test_overflow();
        test_wrap3();
        test_underflow_replace();
        test_depth1();
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
